// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI master between two requesters (req0 = inertial sensor
// interface, req1 = A2D/aux interface). Each requester talks to this block
// exactly as it would talk to the SPI master itself: it pulses snd with a
// command and later sees a done pulse with the response. The arbiter holds
// one pending command per requester, picks a winner when the bus is free,
// forwards the command, routes the response back, and then keeps the bus
// quiet for GAP_CYC cycles so SS_n has a guard time between transactions.
//
// Build option:
//   SPI_ARB_RR_EN defined   -> round-robin on ties (requester not granted
//                              last wins).
//   SPI_ARB_RR_EN undefined -> fixed priority, req0 always wins ties.
//
// Parameters:
//   CMD_W    width of command/response words
//   GAP_CYC  idle cycles between SPI transactions (1..15)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   reqN_snd / reqN_cmd 1-cycle request pulse and its command (N = 0, 1)
//   reqN_done           1-cycle pulse when requester N's transaction ends
//   reqN_resp           last response for requester N, held until next done
//   reqN_busy           requester N has a command pending or in flight
//   reqN_ovr            1-cycle pulse: a snd from N was dropped while busy
//   spi_snd / spi_cmd   start pulse and command toward the SPI master
//   spi_done / spi_resp completion pulse and response from the SPI master
//   grant               one-hot current bus owner (00 = none)
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int CMD_W   = 16,
    parameter int GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_snd,
    input  logic [CMD_W-1:0] req0_cmd,
    output logic             req0_done,
    output logic [CMD_W-1:0] req0_resp,
    output logic             req0_busy,
    output logic             req0_ovr,
    input  logic             req1_snd,
    input  logic [CMD_W-1:0] req1_cmd,
    output logic             req1_done,
    output logic [CMD_W-1:0] req1_resp,
    output logic             req1_busy,
    output logic             req1_ovr,
    output logic             spi_snd,
    output logic [CMD_W-1:0] spi_cmd,
    input  logic             spi_done,
    input  logic [CMD_W-1:0] spi_resp,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t           state;
    logic [3:0]       gap_cnt;
    logic [1:0]       pending;
    logic [CMD_W-1:0] pend_cmd0;
    logic [CMD_W-1:0] pend_cmd1;
    logic             clr0;
    logic             clr1;
    logic             acc0;
    logic             acc1;
    logic             pick1;

    // A requester's pending bit is cleared by the SPI completion of its own
    // transaction. A new snd landing in that very cycle is still accepted,
    // so the set has to win over the clear.
    assign clr0 = (state == BUSY) && spi_done && grant[0];
    assign clr1 = (state == BUSY) && spi_done && grant[1];
    assign acc0 = req0_snd && (!pending[0] || clr0);
    assign acc1 = req1_snd && (!pending[1] || clr1);

    assign req0_busy = pending[0];
    assign req1_busy = pending[1];

`ifdef SPI_ARB_RR_EN
    // 'last' remembers which requester owned the bus most recently
    // (1 = req1); on a tie the other one is served.
    logic last;

    assign pick1 = pending[1] && (!pending[0] || !last);
`else
    // Fixed priority: req1 only wins when req0 has nothing queued.
    assign pick1 = pending[1] && !pending[0];
`endif

    // Pending latches, response routing and the bus FSM all live in one
    // clocked block so every output is a register. Pulse outputs default
    // low each cycle and are raised only for the single cycle they mean
    // something. Reset drops any in-flight request without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pending   <= '0;
            pend_cmd0 <= '0;
            pend_cmd1 <= '0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_ovr  <= 1'b0;
            req1_ovr  <= 1'b0;
            req0_resp <= '0;
            req1_resp <= '0;
            spi_snd   <= 1'b0;
            spi_cmd   <= '0;
            grant     <= 2'b00;
`ifdef SPI_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            spi_snd   <= 1'b0;
            req0_ovr  <= req0_snd && !acc0;
            req1_ovr  <= req1_snd && !acc1;

            if (acc0) begin
                pending[0] <= 1'b1;
                pend_cmd0  <= req0_cmd;
            end else if (clr0) begin
                pending[0] <= 1'b0;
            end

            if (acc1) begin
                pending[1] <= 1'b1;
                pend_cmd1  <= req1_cmd;
            end else if (clr1) begin
                pending[1] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant   <= pick1 ? 2'b10 : 2'b01;
                        spi_cmd <= pick1 ? pend_cmd1 : pend_cmd0;
`ifdef SPI_ARB_RR_EN
                        last    <= pick1;
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    spi_snd <= 1'b1;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (spi_done) begin
                        if (grant[1]) begin
                            req1_resp <= spi_resp;
                            req1_done <= 1'b1;
                        end else begin
                            req0_resp <= spi_resp;
                            req0_done <= 1'b1;
                        end
                        grant   <= 2'b00;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//
// Self-checking bench for spi_arbiter. Directed scenarios cover the exact
// cycle timing (issue latency, guard gap, overrun, reset mid-transaction,
// stray completions); a randomized run compares the arbiter against a
// transaction-level model of the pending slots and the arbitration rule.
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int GAP = 4;

    logic        clk;
    logic        rst_n;
    logic        req0_snd;
    logic [15:0] req0_cmd;
    logic        req0_done;
    logic [15:0] req0_resp;
    logic        req0_busy;
    logic        req0_ovr;
    logic        req1_snd;
    logic [15:0] req1_cmd;
    logic        req1_done;
    logic [15:0] req1_resp;
    logic        req1_busy;
    logic        req1_ovr;
    logic        spi_snd;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_resp;
    logic [1:0]  grant;

    int n_checks;
    int n_fail;

    spi_arbiter #(.CMD_W(16), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_snd(req0_snd), .req0_cmd(req0_cmd), .req0_done(req0_done),
        .req0_resp(req0_resp), .req0_busy(req0_busy), .req0_ovr(req0_ovr),
        .req1_snd(req1_snd), .req1_cmd(req1_cmd), .req1_done(req1_done),
        .req1_resp(req1_resp), .req1_busy(req1_busy), .req1_ovr(req1_ovr),
        .spi_snd(spi_snd), .spi_cmd(spi_cmd), .spi_done(spi_done),
        .spi_resp(spi_resp), .grant(grant)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something in the bench itself never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and land 1 ns after the edge, where outputs are sampled
    // and the next cycle's inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_snd = 1'b0; req0_cmd = '0;
        req1_snd = 1'b0; req1_cmd = '0;
        spi_done = 1'b0; spi_resp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Completes whatever the arbiter issues until both requesters are idle.
    task automatic drain(output logic ok);
        ok = 1'b0;
        clear_inputs();
        for (int w = 0; w < 200 && !ok; w++) begin
            spi_done = spi_snd;
            tick();
            spi_done = 1'b0;
            if (!req0_busy && !req1_busy) ok = 1'b1;
        end
        repeat (GAP + 2) tick();
    endtask

    // Inputs are toggled while reset is held; everything must sit at reset values.
    task automatic test_reset();
        rst_n = 1'b0;
        req0_snd = 1'b1; req0_cmd = 16'h1111;
        req1_snd = 1'b1; req1_cmd = 16'h2222;
        spi_done = 1'b1; spi_resp = 16'h3333;
        tick();
        tick();
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
        n_checks++; if (spi_snd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_spi_snd: got %b want 0", spi_snd); end
        n_checks++; if (spi_cmd !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_spi_cmd: got %h want 0000", spi_cmd); end
        n_checks++; if ({req1_done, req0_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 00", {req1_done, req0_done}); end
        n_checks++; if ({req1_busy, req0_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 00", {req1_busy, req0_busy}); end
        n_checks++; if ({req1_ovr, req0_ovr} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ovr: got %b want 00", {req1_ovr, req0_ovr}); end
        n_checks++; if (req0_resp !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_resp0: got %h want 0000", req0_resp); end
        n_checks++; if (req1_resp !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_resp1: got %h want 0000", req1_resp); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({req1_busy, req0_busy, grant} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_release: got %b want 0000", {req1_busy, req0_busy, grant}); end
    endtask

    // Single req0 transaction with exact latency, then a req1 request queued
    // in the gap to measure the guard time.
    task automatic test_single();
        logic [15:0] r1_prev;
        clear_inputs();
        r1_prev = req1_resp;
        req0_cmd = 16'hA400; req0_snd = 1'b1;
        tick();                                    // cycle 1
        req0_snd = 1'b0;
        n_checks++; if (req0_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b want 1", req0_busy); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL single_grant_c1: got %b want 00", grant); end
        tick();                                    // cycle 2
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("[TB] FAIL single_grant_c2: got %b want 01", grant); end
        n_checks++; if (spi_cmd !== 16'hA400) begin n_fail++; $display("[TB] FAIL single_cmd_c2: got %h want A400", spi_cmd); end
        n_checks++; if (spi_snd !== 1'b0) begin n_fail++; $display("[TB] FAIL single_snd_c2: got %b want 0", spi_snd); end
        tick();                                    // cycle 3
        n_checks++; if (spi_snd !== 1'b1) begin n_fail++; $display("[TB] FAIL single_snd_c3: got %b want 1", spi_snd); end
        n_checks++; if (spi_cmd !== 16'hA400) begin n_fail++; $display("[TB] FAIL single_cmd_c3: got %h want A400", spi_cmd); end
        tick();                                    // cycle 4
        n_checks++; if ({spi_snd, req0_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL single_c4: got %b want 00", {spi_snd, req0_done}); end
        spi_done = 1'b1; spi_resp = 16'h00C3;
        tick();                                    // cycle 5
        spi_done = 1'b0;
        n_checks++; if (req0_done !== 1'b1) begin n_fail++; $display("[TB] FAIL single_done: got %b want 1", req0_done); end
        n_checks++; if (req0_resp !== 16'h00C3) begin n_fail++; $display("[TB] FAIL single_resp: got %h want 00C3", req0_resp); end
        n_checks++; if ({grant, req0_busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL single_release: got %b want 000", {grant, req0_busy}); end
        n_checks++; if ({req1_done, req1_busy, req1_ovr} !== 3'b000) begin n_fail++; $display("[TB] FAIL single_req1_flags: got %b want 000", {req1_done, req1_busy, req1_ovr}); end
        n_checks++; if (req1_resp !== r1_prev) begin n_fail++; $display("[TB] FAIL single_req1_resp: got %h want %h", req1_resp, r1_prev); end
        req1_cmd = 16'h5A5A; req1_snd = 1'b1;
        for (int k = 1; k <= GAP + 2; k++) begin
            n_checks++; if (spi_snd !== 1'b0) begin n_fail++; $display("[TB] FAIL single_gap k=%0d: spi_snd got %b want 0", k, spi_snd); end
            tick();
            req1_snd = 1'b0;
        end
        n_checks++; if (spi_snd !== 1'b1) begin n_fail++; $display("[TB] FAIL single_gap_end: spi_snd got %b want 1", spi_snd); end
        n_checks++; if ({grant, spi_cmd} !== {2'b10, 16'h5A5A}) begin n_fail++; $display("[TB] FAIL single_second: got %b/%h want 10/5A5A", grant, spi_cmd); end
        spi_done = 1'b1; spi_resp = 16'h3C3C;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req1_resp} !== {1'b1, 16'h3C3C}) begin n_fail++; $display("[TB] FAIL single_second_done: got %b/%h want 1/3C3C", req1_done, req1_resp); end
        n_checks++; if (req0_resp !== 16'h00C3) begin n_fail++; $display("[TB] FAIL single_resp_hold: got %h want 00C3", req0_resp); end
        repeat (GAP + 2) tick();
    endtask

    // Both requesters in the same cycle after reset: req0 first in either mode.
    task automatic test_both_same_cycle();
        logic [15:0] r0;
        logic [15:0] r1;
        do_reset();
        r0 = 16'($urandom); r1 = 16'($urandom);
        req0_cmd = 16'hA500; req0_snd = 1'b1;
        req1_cmd = 16'h1234; req1_snd = 1'b1;
        tick();
        clear_inputs();
        tick();
        n_checks++; if ({grant, spi_cmd} !== {2'b01, 16'hA500}) begin n_fail++; $display("[TB] FAIL both_first: got %b/%h want 01/A500", grant, spi_cmd); end
        tick();
        n_checks++; if (spi_snd !== 1'b1) begin n_fail++; $display("[TB] FAIL both_first_snd: got %b want 1", spi_snd); end
        spi_done = 1'b1; spi_resp = r0;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req0_done} !== 2'b01) begin n_fail++; $display("[TB] FAIL both_done0: got %b want 01", {req1_done, req0_done}); end
        n_checks++; if (req0_resp !== r0) begin n_fail++; $display("[TB] FAIL both_resp0: got %h want %h", req0_resp, r0); end
        for (int k = 1; k <= GAP + 2; k++) begin
            n_checks++; if ({spi_snd, req1_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL both_gap k=%0d: got %b want 00", k, {spi_snd, req1_done}); end
            tick();
        end
        n_checks++; if ({spi_snd, grant, spi_cmd} !== {1'b1, 2'b10, 16'h1234}) begin n_fail++; $display("[TB] FAIL both_second: got %b/%b/%h want 1/10/1234", spi_snd, grant, spi_cmd); end
        spi_done = 1'b1; spi_resp = r1;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req0_done} !== 2'b10) begin n_fail++; $display("[TB] FAIL both_done1: got %b want 10", {req1_done, req0_done}); end
        n_checks++; if (req1_resp !== r1) begin n_fail++; $display("[TB] FAIL both_resp1: got %h want %h", req1_resp, r1); end
        repeat (GAP + 2) tick();
    endtask

    // Both requesters re-send on each own done; six grants in a row.
    task automatic test_back_to_back();
        logic [1:0]  exp_grant;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] rsp;
        logic        got;
        logic        ok;
        do_reset();
        c0 = 16'h0B00; c1 = 16'h1B00;
        req0_cmd = c0; req0_snd = 1'b1;
        req1_cmd = c1; req1_snd = 1'b1;
        tick();
        clear_inputs();
        for (int t = 0; t < 6; t++) begin
            got = 1'b0;
            for (int w = 0; w < 30 && !got; w++) begin
                if (spi_snd) got = 1'b1;
                else tick();
            end
            n_checks++;
            if (!got) begin n_fail++; $display("[TB] FAIL b2b_timeout t=%0d: spi_snd got 0 want 1", t); break; end
`ifdef SPI_ARB_RR_EN
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            n_checks++; if (grant !== exp_grant) begin n_fail++; $display("[TB] FAIL b2b_grant t=%0d: got %b want %b", t, grant, exp_grant); end
            n_checks++; if (spi_cmd !== (exp_grant[0] ? c0 : c1)) begin n_fail++; $display("[TB] FAIL b2b_cmd t=%0d: got %h want %h", t, spi_cmd, exp_grant[0] ? c0 : c1); end
            rsp = 16'($urandom);
            spi_done = 1'b1; spi_resp = rsp;
            tick();
            spi_done = 1'b0;
            n_checks++; if ({req1_done, req0_done} !== exp_grant) begin n_fail++; $display("[TB] FAIL b2b_done t=%0d: got %b want %b", t, {req1_done, req0_done}, exp_grant); end
            n_checks++; if ((exp_grant[0] ? req0_resp : req1_resp) !== rsp) begin n_fail++; $display("[TB] FAIL b2b_resp t=%0d: got %h want %h", t, exp_grant[0] ? req0_resp : req1_resp, rsp); end
            if (exp_grant[0]) begin c0 = c0 + 16'd1; req0_cmd = c0; req0_snd = 1'b1; end
            else begin c1 = c1 + 16'd1; req1_cmd = c1; req1_snd = 1'b1; end
            tick();
            clear_inputs();
        end
        drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL b2b_drain: busy got %b want 00", {req1_busy, req0_busy}); end
    endtask

    // req1 sends again while busy with FFFF: overrun pulse, original goes out.
    task automatic test_overrun();
        logic [15:0] orig;
        logic [15:0] rsp;
        clear_inputs();
        orig = 16'($urandom_range(0, 16'hFFFE));
        rsp  = 16'($urandom);
        req1_cmd = orig; req1_snd = 1'b1;
        tick();                                    // cycle 1
        n_checks++; if (req1_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_busy: got %b want 1", req1_busy); end
        req1_cmd = 16'hFFFF;
        tick();                                    // cycle 2
        req1_snd = 1'b0;
        n_checks++; if (req1_ovr !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_pulse: got %b want 1", req1_ovr); end
        n_checks++; if ({grant, spi_cmd} !== {2'b10, orig}) begin n_fail++; $display("[TB] FAIL ovr_grant: got %b/%h want 10/%h", grant, spi_cmd, orig); end
        tick();                                    // cycle 3
        n_checks++; if ({req1_ovr, spi_snd} !== 2'b01) begin n_fail++; $display("[TB] FAIL ovr_c3: got %b want 01", {req1_ovr, spi_snd}); end
        n_checks++; if (spi_cmd !== orig) begin n_fail++; $display("[TB] FAIL ovr_cmd: got %h want %h", spi_cmd, orig); end
        spi_done = 1'b1; spi_resp = rsp;
        tick();                                    // cycle 4
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req1_resp} !== {1'b1, rsp}) begin n_fail++; $display("[TB] FAIL ovr_done: got %b/%h want 1/%h", req1_done, req1_resp, rsp); end
        req0_cmd = 16'h0404; req0_snd = 1'b1;
        for (int k = 1; k <= GAP + 2; k++) begin
            n_checks++; if (spi_snd !== 1'b0 || spi_cmd === 16'hFFFF) begin n_fail++; $display("[TB] FAIL ovr_gap k=%0d: got %b/%h want 0/not FFFF", k, spi_snd, spi_cmd); end
            tick();
            req0_snd = 1'b0;
        end
        n_checks++; if ({spi_snd, grant, spi_cmd} !== {1'b1, 2'b01, 16'h0404}) begin n_fail++; $display("[TB] FAIL ovr_next: got %b/%b/%h want 1/01/0404", spi_snd, grant, spi_cmd); end
        spi_done = 1'b1; spi_resp = 16'h4040;
        tick();
        spi_done = 1'b0;
        n_checks++; if (req0_done !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_next_done: got %b want 1", req0_done); end
        n_checks++; if (req1_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_not_queued: got %b want 0", req1_busy); end
        repeat (GAP + 2) tick();
    endtask

    // Reset pulse during BUSY drops the request; a fresh request still works.
    task automatic test_reset_mid();
        clear_inputs();
        req0_cmd = 16'h7E00; req0_snd = 1'b1;
        tick();
        req0_snd = 1'b0;
        tick();
        tick();                                    // cycle 3
        n_checks++; if (spi_snd !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pre: spi_snd got %b want 1", spi_snd); end
        tick();                                    // cycle 4, BUSY
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if ({grant, req0_busy, spi_snd, req0_done} !== 5'b00000) begin n_fail++; $display("[TB] FAIL rstmid_after: got %b want 00000", {grant, req0_busy, spi_snd, req0_done}); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++; if ({req0_done, spi_snd} !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid_quiet k=%0d: got %b want 00", k, {req0_done, spi_snd}); end
        end
        req0_cmd = 16'h7E01; req0_snd = 1'b1;
        tick();
        req0_snd = 1'b0;
        tick();
        tick();
        n_checks++; if ({spi_snd, spi_cmd} !== {1'b1, 16'h7E01}) begin n_fail++; $display("[TB] FAIL rstmid_fresh: got %b/%h want 1/7E01", spi_snd, spi_cmd); end
        spi_done = 1'b1; spi_resp = 16'h9999;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req0_done, req0_resp} !== {1'b1, 16'h9999}) begin n_fail++; $display("[TB] FAIL rstmid_done: got %b/%h want 1/9999", req0_done, req0_resp); end
        repeat (GAP + 2) tick();
    endtask

    // Stray spi_done while IDLE and while in the guard gap must be ignored.
    task automatic test_spurious_done();
        logic [15:0] r0;
        logic [15:0] r1;
        clear_inputs();
        r0 = req0_resp; r1 = req1_resp;
        spi_done = 1'b1; spi_resp = 16'hBEEF;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req0_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL spur_idle_done: got %b want 00", {req1_done, req0_done}); end
        tick();
        n_checks++; if ({req0_resp, req1_resp} !== {r0, r1}) begin n_fail++; $display("[TB] FAIL spur_idle_resp: got %h/%h want %h/%h", req0_resp, req1_resp, r0, r1); end
        n_checks++; if ({grant, req1_busy, req0_busy, spi_snd} !== 5'b00000) begin n_fail++; $display("[TB] FAIL spur_idle_state: got %b want 00000", {grant, req1_busy, req0_busy, spi_snd}); end
        req0_cmd = 16'h6601; req0_snd = 1'b1;
        tick();
        req0_snd = 1'b0;
        tick();
        tick();
        spi_done = 1'b1; spi_resp = 16'h1111;
        tick();                                    // first gap cycle
        spi_done = 1'b0;
        n_checks++; if ({req0_done, req0_resp} !== {1'b1, 16'h1111}) begin n_fail++; $display("[TB] FAIL spur_real_done: got %b/%h want 1/1111", req0_done, req0_resp); end
        tick();
        spi_done = 1'b1; spi_resp = 16'hDEAD;
        tick();
        spi_done = 1'b0;
        n_checks++; if ({req1_done, req0_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL spur_gap_done: got %b want 00", {req1_done, req0_done}); end
        tick();
        n_checks++; if ({req0_resp, req1_resp} !== {16'h1111, r1}) begin n_fail++; $display("[TB] FAIL spur_gap_resp: got %h/%h want 1111/%h", req0_resp, req1_resp, r1); end
        n_checks++; if ({grant, spi_snd} !== 3'b000) begin n_fail++; $display("[TB] FAIL spur_gap_state: got %b want 000", {grant, spi_snd}); end
        repeat (GAP + 2) tick();
    endtask

    // Random traffic against a transaction-level model: one slot per
    // requester, an arbitration rule applied to the slots as they stood when
    // the bus was free (two cycles before spi_snd), and an SPI responder with
    // random latency plus occasional stray completions.
    task automatic test_random();
        logic [1:0]  p;
        logic [1:0]  ph1;
        logic [1:0]  ph2;
        logic [15:0] pcm [2];
        logic [15:0] hc1 [2];
        logic [15:0] hc2 [2];
        logic [15:0] exp_resp [2];
        logic [1:0]  exp_done;
        logic [1:0]  exp_ovr;
        logic [1:0]  s;
        logic [15:0] c [2];
        logic        outstanding;
        logic        owner;
        logic        win;
        logic        mlast;
        logic        done_now;
        logic        sending;
        logic [15:0] ocmd;
        int          lat;
        int          stall;
        do_reset();
        p = '0; ph1 = '0; ph2 = '0;
        for (int i = 0; i < 2; i++) begin pcm[i] = '0; hc1[i] = '0; hc2[i] = '0; exp_resp[i] = '0; c[i] = '0; end
        outstanding = 1'b0; owner = 1'b0; mlast = 1'b1; ocmd = '0; lat = 0; stall = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            sending  = (cyc < 1450);
            done_now = outstanding && (lat == 0);
            if (outstanding && lat > 0) lat--;
            spi_done = done_now || (!outstanding && ($urandom_range(0, 15) == 0));
            spi_resp = 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                s[i] = sending && ($urandom_range(0, 3) == 0);
                c[i] = 16'($urandom);
            end
            req0_snd = s[0]; req0_cmd = c[0];
            req1_snd = s[1]; req1_cmd = c[1];
            exp_done = '0;
            exp_ovr  = '0;
            if (done_now) begin
                exp_done[owner] = 1'b1;
                exp_resp[owner] = spi_resp;
                p[owner]        = 1'b0;
                outstanding     = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (s[i] && !p[i]) begin p[i] = 1'b1; pcm[i] = c[i]; end
                else if (s[i]) exp_ovr[i] = 1'b1;
            end
            tick();
            n_checks++; if ({req1_done, req0_done} !== exp_done) begin n_fail++; $display("[TB] FAIL rnd_done cyc=%0d: got %b want %b", cyc, {req1_done, req0_done}, exp_done); end
            n_checks++; if ({req1_ovr, req0_ovr} !== exp_ovr) begin n_fail++; $display("[TB] FAIL rnd_ovr cyc=%0d: got %b want %b", cyc, {req1_ovr, req0_ovr}, exp_ovr); end
            n_checks++; if ({req1_busy, req0_busy} !== p) begin n_fail++; $display("[TB] FAIL rnd_busy cyc=%0d: got %b want %b", cyc, {req1_busy, req0_busy}, p); end
            n_checks++; if ({req1_resp, req0_resp} !== {exp_resp[1], exp_resp[0]}) begin n_fail++; $display("[TB] FAIL rnd_resp cyc=%0d: got %h/%h want %h/%h", cyc, req1_resp, req0_resp, exp_resp[1], exp_resp[0]); end
            if (spi_snd) begin
                n_checks++;
                if (outstanding || ph2 == 2'b00) begin
                    n_fail++; $display("[TB] FAIL rnd_unexpected_snd cyc=%0d: got spi_snd 1 want 0", cyc);
                end else begin
`ifdef SPI_ARB_RR_EN
                    win = (ph2 == 2'b11) ? !mlast : ph2[1];
`else
                    win = (ph2 == 2'b11) ? 1'b0 : ph2[1];
`endif
                    if (grant !== (win ? 2'b10 : 2'b01) || spi_cmd !== hc2[win]) begin
                        n_fail++; $display("[TB] FAIL rnd_issue cyc=%0d: got %b/%h want %b/%h", cyc, grant, spi_cmd, win ? 2'b10 : 2'b01, hc2[win]);
                    end
                    owner = win; ocmd = hc2[win]; mlast = win;
                    outstanding = 1'b1; lat = int'($urandom_range(0, 4));
                end
            end else if (outstanding) begin
                n_checks++; if ({grant, spi_cmd} !== {(owner ? 2'b10 : 2'b01), ocmd}) begin n_fail++; $display("[TB] FAIL rnd_hold cyc=%0d: got %b/%h want %b/%h", cyc, grant, spi_cmd, owner ? 2'b10 : 2'b01, ocmd); end
            end
            if (p != 2'b00 && !outstanding) stall++;
            else stall = 0;
            n_checks++; if (stall > GAP + 5) begin n_fail++; $display("[TB] FAIL rnd_stall cyc=%0d: waited %0d cycles, limit %0d", cyc, stall, GAP + 5); end
            ph2 = ph1; ph1 = p;
            hc2 = hc1; hc1 = pcm;
        end
        clear_inputs();
        n_checks++; if ({req1_busy, req0_busy, p} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rnd_final_idle: got %b/%b want 00/00", {req1_busy, req0_busy}, p); end
    endtask

    // Scenarios run in order; every one leaves the arbiter idle for the next.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_both_same_cycle();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_spurious_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
